// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises kbd_clk/kbd_dat, decodes start/data/parity/stop frames, queues words in a FWFT FIFO.
// Optional inactivity abort is enabled by defining PS2_FRAME_RX_TIMEOUT_EN.
module ps2_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          kbd_clk,
  input  logic                          kbd_dat,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          timeout_err
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  generate
    if (DATA_W < 5 || DATA_W > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("ps2_frame_rx: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAR   = 3'd2,
    STOP  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Odd mode wants an odd number of ones over data plus parity; even mode an even number.
  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    logic ones_odd;
    ones_odd = (^d) ^ p;
    if (PARITY_MODE == 0) begin
      return ones_odd;
    end else if (PARITY_MODE == 1) begin
      return ~ones_odd;
    end else begin
      return 1'b1;
    end
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_prev_r;
  logic                   fall_s;
  logic                   bit_s;

  // Input synchronisers; reset to the idle-high bus level so no false edge appears at release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], kbd_clk};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], kbd_dat};
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
  assign bit_s  = dat_sync_r[SYNC_STAGES-1];

  state_t              state_r, state_n;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_n;
  logic [DATA_W-1:0]   shift_r, shift_n;
  logic                par_r, par_n;
  logic                stop_r, stop_n;
  logic                push_s;
  logic                perr_s;
  logic                ferr_s;
  logic                tmo_hit_s;

`ifdef PS2_FRAME_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_n;

  // Inactivity counter: runs only mid-frame and restarts on every detected edge.
  always_comb begin
    tmo_cnt_n = tmo_cnt_r;
    tmo_hit_s = 1'b0;
    if (state_r == DATA || state_r == PAR || state_r == STOP) begin
      if (fall_s) begin
        tmo_cnt_n = {TMO_W{1'b0}};
      end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
        tmo_hit_s = 1'b1;
        tmo_cnt_n = {TMO_W{1'b0}};
      end else begin
        tmo_cnt_n = tmo_cnt_r + TMO_W'(1);
      end
    end else begin
      tmo_cnt_n = {TMO_W{1'b0}};
    end
  end

  // Inactivity counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_n;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Frame decoder next-state and CHECK-cycle verdict.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    par_n     = par_r;
    stop_n    = stop_r;
    push_s    = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    if (tmo_hit_s) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s && !bit_s) begin
            state_n   = DATA;
            bit_cnt_n = {CNT_W{1'b0}};
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (fall_s) begin
            shift_n   = {bit_s, shift_r[DATA_W-1:1]};
            bit_cnt_n = bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
              state_n = (PARITY_MODE == 2) ? STOP : PAR;
            end else begin
              state_n = DATA;
            end
          end else begin
            state_n = DATA;
          end
        end
        PAR: begin
          if (fall_s) begin
            par_n   = bit_s;
            state_n = STOP;
          end else begin
            state_n = PAR;
          end
        end
        STOP: begin
          if (fall_s) begin
            stop_n  = bit_s;
            state_n = CHECK;
          end else begin
            state_n = STOP;
          end
        end
        CHECK: begin
          state_n = IDLE;
          if (!stop_r) begin
            ferr_s = 1'b1;
          end else if (!parity_ok(shift_r, par_r)) begin
            perr_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Frame decoder registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r   <= IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_r     <= 1'b0;
      stop_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      stop_r    <= stop_n;
    end
  end

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_n;
  logic [FCNT_W-1:0] count_n;
  logic [DATA_W-1:0] head_n;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              ovf_s;

  // FIFO control; head_n precomputes next cycle's dout so the output stays registered yet first-word-fall-through.
  always_comb begin
    pop_s    = dout_valid & dout_ready;
    full_s   = (fifo_count == FCNT_W'(FIFO_DEPTH));
    wr_en_s  = push_s & (~full_s | pop_s);
    ovf_s    = push_s & full_s & ~pop_s;
    rd_ptr_n = pop_s   ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
    wr_ptr_n = wr_en_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_n = fifo_count + FCNT_W'(1);
      2'b01:   count_n = fifo_count - FCNT_W'(1);
      default: count_n = fifo_count;
    endcase
    if (count_n == {FCNT_W{1'b0}}) begin
      head_n = {DATA_W{1'b0}};
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_n)) begin
      head_n = shift_r;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // FIFO storage, pointers and registered outputs including the error pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      fifo_count  <= {FCNT_W{1'b0}};
      dout        <= {DATA_W{1'b0}};
      dout_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
      end
      rd_ptr_r    <= rd_ptr_n;
      wr_ptr_r    <= wr_ptr_n;
      fifo_count  <= count_n;
      dout        <= head_n;
      dout_valid  <= (count_n != {FCNT_W{1'b0}});
      parity_err  <= perr_s;
      frame_err   <= ferr_s;
      overflow    <= ovf_s;
    end
  end

`ifdef PS2_FRAME_RX_TIMEOUT_EN
  // Timeout pulse register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit_s;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised self-checking bench for ps2_frame_rx against a queue-based frame model.
module tb_ps2_frame_rx;

  localparam int DW = 8;
  localparam int FD = 4;
`ifdef PS2_FRAME_RX_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 50000;
`endif

  logic          clk = 1'b0;
  logic          resetN;
  logic          kbd_clk;
  logic          kbd_dat;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [2:0]    fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;
  logic          timeout_err;

  always #5 clk = ~clk;

  ps2_frame_rx #(
    .DATA_W(DW), .PARITY_MODE(0), .FIFO_DEPTH(FD), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .resetN(resetN), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: words the receiver should deliver, in order.
  logic [DW-1:0] exp_q[$];
  int perr_n = 0, ferr_n = 0, ovf_n = 0, tmo_n = 0, pops_n = 0;

  // Pulse counters and head/pop scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (parity_err)  perr_n++;
    if (frame_err)   ferr_n++;
    if (overflow)    ovf_n++;
    if (timeout_err) tmo_n++;
    if (resetN && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("dout_head", dout, exp_q[0]);
        if (dout_ready) begin
          void'(exp_q.pop_front());
          pops_n++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    kbd_dat = b;
    cyc(4);
    kbd_clk = 1'b0;
    cyc(8);
    kbd_clk = 1'b1;
    cyc(4);
  endtask

  function automatic logic odd_par(input logic [DW-1:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input bit chk_lat);
    int  lat, pe0, fe0, ov0;
    bit  good, par_good, exp_ovf;
    pe0 = perr_n; fe0 = ferr_n; ov0 = ovf_n;
    ps2_bit(1'b0);
    for (int i = 0; i < DW; i++) ps2_bit(d[i]);
    ps2_bit(p);
    par_good = (($countones(d) + int'(p)) % 2) == 1;
    good     = s && par_good;
    exp_ovf  = good && (exp_q.size() >= FD);
    if (good && !exp_ovf) exp_q.push_back(d);
    kbd_dat = s;
    cyc(4);
    kbd_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (dout_valid && lat == 0) lat = i;
    end
    kbd_clk = 1'b1;
    cyc(4);
    if (chk_lat) check("valid_latency", lat, 4);
    check("frame_err_pulses", ferr_n - fe0, {31'd0, !s});
    check("parity_err_pulses", perr_n - pe0, {31'd0, s && !par_good});
    check("overflow_pulses", ovf_n - ov0, {31'd0, exp_ovf});
  endtask

  initial begin
    int kind, p0, t0, tcyc;
    logic [DW-1:0] d;
    resetN = 1'b0; kbd_clk = 1'b1; kbd_dat = 1'b1; dout_ready = 1'b0;
    cyc(3);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_errs", {parity_err, frame_err, overflow, timeout_err}, 0);
    resetN = 1'b1;
    cyc(5);

    // Good frame into empty FIFO
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("count_after_1c", fifo_count, 1);
    check("dout_1c", dout, 32'h1C);
    dout_ready = 1'b1;
    cyc(3);
    check("count_drained", fifo_count, 0);
    dout_ready = 1'b0;

    // Parity error, framing errors (framing wins over parity)
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("count_after_perr", fifo_count, 0);
    check("valid_after_perr", dout_valid, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("count_after_ferr", fifo_count, 0);

    // Fill and overflow with ready low
    for (int v = 1; v <= 5; v++) begin
      d = DW'(v);
      send_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    check("count_full", fifo_count, 4);
    check("dout_stable_full", dout, 32'h01);
    p0 = pops_n;
    dout_ready = 1'b1;
    cyc(10);
    check("pops_after_full", pops_n - p0, 4);
    check("count_after_pops", fifo_count, 0);

    // Randomised frames; ready fixed per frame so occupancy at push matches the model
    for (int n = 0; n < 24; n++) begin
      dout_ready = 1'($urandom_range(0, 1));
      d    = DW'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0)      send_frame(d, odd_par(d), 1'b0, 1'b0);
      else if (kind == 1) send_frame(d, ~odd_par(d), 1'b1, 1'b0);
      else                send_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    dout_ready = 1'b1;
    cyc(10);
    check("count_after_random", fifo_count, 0);
    check("model_empty", exp_q.size(), 0);

`ifdef PS2_FRAME_RX_TIMEOUT_EN
    t0 = tmo_n;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    tcyc = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      if (tmo_n != t0 && tcyc == 0) tcyc = i;
    end
    check("timeout_window", (tcyc >= 80 && tcyc <= 105) ? 1 : 0, 1);
    check("timeout_pulses", tmo_n - t0, 1);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
    cyc(5);
    check("count_after_f0", fifo_count, 0);
`else
    t0 = tmo_n;
    tcyc = 0;
    check("timeout_never", tmo_n, 0);
`endif

    // Reset mid-frame with a word pending
    dout_ready = 1'b0;
    send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0);
    check("count_before_rst", fifo_count, 1);
    ps2_bit(1'b0);
    d = 8'hA5;
    for (int i = 0; i < 4; i++) ps2_bit(d[i]);
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_dout", dout, 0);
    check("midrst_valid", dout_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_errs", {parity_err, frame_err, overflow, timeout_err}, 0);
    exp_q.delete();
    cyc(2);
    resetN = 1'b1;
    cyc(3);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
    check("count_after_5a", fifo_count, 1);
    check("dout_5a", dout, 32'h5A);
    dout_ready = 1'b1;
    cyc(5);
    check("count_end", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 = odd, 1 = even, 2 = no parity bit in frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, at least 2).
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per PS/2 input (at least 2).
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 50000, meaning clk cycles without a PS/2 clock edge before frame abort.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-007 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port kbd_clk, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-009 The block SHALL have port kbd_dat, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-010 The block SHALL have port dout, output, DATA_W bits: FIFO head word.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: FIFO non-empty.
REQ-012 The block SHALL have port dout_ready, input, 1 bit: consumer pops the head when dout_valid and dout_ready are both high.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: stored entries.
REQ-014 The block SHALL have ports parity_err, frame_err, overflow and timeout_err, outputs, 1 bit each, each a one-cycle error pulse.

Function
REQ-015 kbd_clk and kbd_dat SHALL each pass through SYNC_STAGES flops; a PS/2 falling edge is synchronised kbd_clk going 1->0 between consecutive clk cycles.
REQ-016 Synchronised kbd_dat SHALL be sampled only in the cycle a falling edge is detected.
REQ-017 The FSM SHALL have states IDLE, DATA, PAR, STOP and CHECK.
REQ-018 IDLE: on an edge with data 0 (start bit), go to DATA and clear the bit counter; on an edge with data 1, stay in IDLE and do nothing.
REQ-019 DATA: shift sampled bits in LSB-first; after DATA_W bits, go to PAR, or to STOP when PARITY_MODE = 2.
REQ-020 PAR: capture the parity bit on the next edge, then go to STOP.
REQ-021 STOP: capture the stop bit on the next edge, then go to CHECK.
REQ-022 CHECK SHALL last exactly one cycle and then go to IDLE.
REQ-023 In CHECK, a stop bit of 0 SHALL pulse frame_err, with no push; frame_err has priority over parity_err.
REQ-024 In CHECK, otherwise a parity mismatch SHALL pulse parity_err, with no push; odd mode requires an odd count of ones over data plus parity, even mode an even count.
REQ-025 In CHECK, otherwise the data word SHALL be pushed to the FIFO.
REQ-026 With an empty FIFO, dout_valid SHALL rise 2 clk cycles after the cycle the stop edge is detected.
REQ-027 The FIFO SHALL be first-word-fall-through; dout is held stable while dout_valid is high and dout_ready is low.
REQ-028 A push into a full FIFO without a simultaneous pop SHALL drop the word and pulse overflow, with FIFO contents unchanged.
REQ-029 A push and pop in the same cycle when full SHALL both succeed, with fifo_count unchanged and no overflow.
REQ-030 A push and pop in the same cycle when empty SHALL be impossible, since pop requires dout_valid.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
REQ-032 The bit counter SHALL be $clog2(DATA_W+1) bits and SHALL NOT wrap within a frame.

Reset
REQ-033 Asserting resetN low SHALL immediately force state IDLE, counters, pointers and fifo_count to 0, dout to 0, and dout_valid and all error pulses to 0.
REQ-034 Asserting resetN low SHALL force synchroniser flops to 1 (idle bus).
REQ-035 Reset mid-frame SHALL discard the partial frame; the first full frame after release SHALL be received normally.

Configuration
REQ-036 With macro PS2_FRAME_RX_TIMEOUT_EN defined, a cycle counter in DATA/PAR/STOP SHALL clear on every detected edge.
REQ-037 With PS2_FRAME_RX_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL force IDLE, discard the partial frame and pulse timeout_err.
REQ-038 Without PS2_FRAME_RX_TIMEOUT_EN, no counter SHALL exist, timeout_err is tied 0, and the FSM waits indefinitely.

Verification
REQ-039 Frame with data 0x1C, parity 0, stop 1, in default odd mode -> dout = 0x1C, dout_valid at stop edge +2 cycles, fifo_count = 1, no error pulse.
REQ-040 Same frame with parity 1 -> parity_err pulses one cycle, fifo_count stays 0, dout_valid stays 0.
REQ-041 Frame with data 0x1C, parity 0, stop 0 -> frame_err pulses, parity_err stays 0, no push.
REQ-042 dout_ready = 0 and frames 0x01..0x05 -> fifo_count = 4, overflow pulses on the 5th; releasing ready pops 0x01..0x04 in order.
REQ-043 TIMEOUT_CYC = 100 with the macro defined: start plus 3 bits then kbd_clk held high -> timeout_err at 100 idle cycles, then a 0xF0 frame is received correctly.
REQ-044 resetN pulsed low after the 4th data bit -> all outputs 0 immediately, then the next 0x5A frame is received correctly.
